// File: rtl/rx_os_lane_counters_pkg.sv
// rtl/rx_os_lane_counters_pkg.sv - shared encodings for the ordered-set lane counters
package rx_os_lane_counters_pkg;

    localparam int COUNT_W = 5;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd31;

    localparam logic [1:0] OS_OTHER = 2'd0;
    localparam logic [1:0] OS_TS1   = 2'd1;
    localparam logic [1:0] OS_TS2   = 2'd2;
    localparam logic [1:0] OS_SKP   = 2'd3;

    typedef enum logic [1:0] {
        LANE_DISABLED = 2'd0,
        LANE_HUNT     = 2'd1,
        LANE_MATCH    = 2'd2
    } laneState_t;

endpackage

// File: rtl/rx_os_lane_counter.sv
// rtl/rx_os_lane_counter.sv - per-lane consecutive ordered-set counter with sticky threshold flag
module rx_os_lane_counter
    import rx_os_lane_counters_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               osValid,
    input  logic [1:0]         osType,
    input  logic [7:0]         osLinkNum,
    input  logic [7:0]         osLaneNum,
    input  logic [1:0]         expectedType,
    input  logic [COUNT_W-1:0] comparatorsCount,
    output logic               met,
    output logic [7:0]         linkNum,
    output logic [7:0]         laneNum
);

    laneState_t         state, stateNext;
    logic [COUNT_W-1:0] count, countNext;
    logic [7:0]         linkNext, laneNext;

    always_comb begin
        stateNext = state;
        countNext = count;
        linkNext  = linkNum;
        laneNext  = laneNum;
        if (state == LANE_DISABLED) begin
            stateNext = LANE_HUNT;
        end else if (osValid && osType != OS_SKP) begin
            if (osType == expectedType) begin
                stateNext = LANE_MATCH;
                if (state == LANE_MATCH && osLinkNum == linkNum && osLaneNum == laneNum) begin
                    countNext = (count == COUNT_MAX) ? count : count + 5'd1;
                end else begin
                    linkNext  = osLinkNum;
                    laneNext  = osLaneNum;
                    countNext = 5'd1;
                end
            end else begin
                stateNext = LANE_HUNT;
                countNext = '0;
            end
        end
    end

    // The flag looks at the next count so it rises in the same edge as the qualifying set.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state   <= LANE_DISABLED;
            count   <= '0;
            met     <= 1'b0;
            linkNum <= '0;
            laneNum <= '0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            linkNum <= linkNext;
            laneNum <= laneNext;
            met     <= met || (state != LANE_DISABLED && countNext >= comparatorsCount);
        end
    end

endmodule

// File: rtl/rx_os_lane_counters.sv
// rtl/rx_os_lane_counters.sv - per-lane TS1/TS2 run counters; slices the lane buses
module rx_os_lane_counters
    import rx_os_lane_counters_pkg::*;
#(
    parameter int MAXLANES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MAXLANES-1:0]   osValid,
    input  logic [2*MAXLANES-1:0] osType,
    input  logic [8*MAXLANES-1:0] osLinkNum,
    input  logic [8*MAXLANES-1:0] osLaneNum,
    input  logic [1:0]            expectedType,
    input  logic [MAXLANES-1:0]   resetOsCheckers,
    input  logic [COUNT_W-1:0]    comparatorsCount,
    output logic [MAXLANES-1:0]   countersComparators,
    output logic [8*MAXLANES-1:0] capturedLinkNum,
    output logic [8*MAXLANES-1:0] capturedLaneNum
);

    for (genvar i = 0; i < MAXLANES; i++) begin : gLane
        rx_os_lane_counter uLane (
            .clk              (clk),
            .reset            (reset),
            .enable           (resetOsCheckers[i]),
            .osValid          (osValid[i]),
            .osType           (osType[2*i +: 2]),
            .osLinkNum        (osLinkNum[8*i +: 8]),
            .osLaneNum        (osLaneNum[8*i +: 8]),
            .expectedType     (expectedType),
            .comparatorsCount (comparatorsCount),
            .met              (countersComparators[i]),
            .linkNum          (capturedLinkNum[8*i +: 8]),
            .laneNum          (capturedLaneNum[8*i +: 8])
        );
    end

endmodule

// File: doc/rx_os_lane_counters.md
RX_OS_LANE_COUNTERS -- requirements
Module: rx_os_lane_counters

Interface
REQ-001 SHALL have parameter MAXLANES, default 16, meaning the number of lanes checked; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clk.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port osValid, input, MAXLANES bits: one bit per lane, high for one cycle when a decoded ordered set is presented.
REQ-005 SHALL have port osType, input, 2*MAXLANES bits: per-lane type code (0 other, 1 TS1, 2 TS2, 3 SKP).
REQ-006 SHALL have port osLinkNum, input, 8*MAXLANES bits: per-lane link-number symbol of the presented ordered set.
REQ-007 SHALL have port osLaneNum, input, 8*MAXLANES bits: per-lane lane-number symbol of the presented ordered set.
REQ-008 SHALL have port expectedType, input, 2 bits: the ordered-set type being counted (TS1 or TS2).
REQ-009 SHALL have port resetOsCheckers, input, MAXLANES bits: per-lane enable; 0 clears and holds that lane, 1 lets it count.
REQ-010 SHALL have port comparatorsCount, input, 5 bits: required number of consecutive identical ordered sets.
REQ-011 SHALL have port countersComparators, output, MAXLANES bits: per-lane threshold-met flag.
REQ-012 SHALL have port capturedLinkNum, output, 8*MAXLANES bits: per-lane link number of the current matching run.
REQ-013 SHALL have port capturedLaneNum, output, 8*MAXLANES bits: per-lane lane number of the current matching run.

Function
REQ-014 Each lane SHALL run an independent FSM with states DISABLED, HUNT and MATCH, plus a 5-bit count, an 8-bit link register, an 8-bit lane register and a met flag.
REQ-015 When resetOsCheckers[i]=0, lane i SHALL enter DISABLED and clear count, met and both captured fields to 0; this takes priority over osValid.
REQ-016 In DISABLED, when resetOsCheckers[i]=1, lane i SHALL move to HUNT on the next cycle.
REQ-017 In HUNT, when osValid=1 and osType=expectedType, the lane SHALL capture the link and lane symbols, set count=1 and move to MATCH.
REQ-018 In MATCH, on a valid ordered set of expectedType:
- if link and lane symbols equal the captured values, count SHALL increment, saturating at 31;
- otherwise the lane SHALL recapture the symbols and set count=1.
REQ-019 In MATCH or HUNT, a valid ordered set of type other or TS-not-expected SHALL set count=0 and return the lane to HUNT.
REQ-020 SKP ordered sets SHALL be ignored: no count change and no state change.
REQ-021 Cycles with osValid[i]=0 SHALL hold all lane i state.
REQ-022 The met flag SHALL be set in the cycle after the count first reaches a value of at least comparatorsCount while enabled.
REQ-023 The met flag SHALL then remain sticky until the lane is disabled, even if the count later drops.
REQ-024 If comparatorsCount=0, the met flag SHALL be set one cycle after the lane leaves DISABLED.
REQ-025 countersComparators[i] SHALL equal met[i]; capturedLinkNum and capturedLaneNum SHALL be the registered captured values.
REQ-026 All outputs SHALL be registered; latency from the qualifying osValid edge to countersComparators SHALL be 1 cycle.
REQ-027 A change of expectedType mid-run SHALL take effect on the next valid ordered set; a non-matching set resets the count per REQ-019.
REQ-028 comparatorsCount changes SHALL be evaluated every cycle against the current count, with no latching.

Reset
REQ-029 While reset=1, every lane SHALL be in DISABLED with count, met and both captured fields at 0, so all outputs read 0.
REQ-030 reset asserted mid-run SHALL clear all lanes at the next clk edge.
REQ-031 After reset deasserts, counting SHALL resume only via REQ-016.

Structure
REQ-032 The shared package SHALL hold the OS type encodings (OS_OTHER, OS_TS1, OS_TS2, OS_SKP), COUNT_W=5, COUNT_MAX=31 and the lane-FSM state encodings.
REQ-033 The per-lane logic SHALL be the sub-module rx_os_lane_counter, instantiated MAXLANES times by a generate loop; the top level only slices buses.

Verification
REQ-034 With 4 lanes enabled, expectedType=TS1, comparatorsCount=8, and 8 identical TS1 sets (link 0x00, lane i), countersComparators SHALL read 0x000F one cycle after the 8th set and SHALL not assert earlier.
REQ-035 Lane 0 receives 5 TS1 sets, then 1 TS2 set, then 7 TS1 sets with comparatorsCount=8: countersComparators[0] SHALL stay 0; an 8th TS1 set SHALL set it to 1.
REQ-036 Lane 2 receives 3 TS1 sets with lane=0x02, then 1 with lane=0x05: count SHALL become 1 and capturedLaneNum[2] SHALL read 0x05.
REQ-037 Lane 1 receives TS1 sets interleaved with SKP sets, comparatorsCount=2: SKP sets SHALL not break the run, and the flag SHALL set after the 2nd TS1 set.
REQ-038 With the flag met on lane 0, driving resetOsCheckers[0]=0 together with a valid TS1 set SHALL clear the flag and captured fields the next cycle; reset=1 mid-run SHALL zero all outputs on the next edge.
REQ-039 With comparatorsCount=0, enabling lane 3 SHALL set countersComparators[3] one cycle after HUNT is entered, with no ordered sets received; 40 identical sets SHALL saturate the count at 31 with no wrap.
